// File: rtl/fnd_pkg.sv
// Shared constants, state encoding and helpers for the 7-segment scan display.
package fnd_pkg;

  localparam int DIGITS    = 4;
  localparam int MAX_VALUE = 9999;
  localparam int BIN_W     = 14;
  localparam int BCD_W     = 16;

  localparam logic [BIN_W-1:0] MAX_VALUE_BIN = 14'd9999;
  localparam logic [3:0]       SHIFT_COUNT   = 4'd14;
  localparam logic [7:0]       FND_BLANK     = 8'hFF;

  // Active-low segment patterns {dp,g,f,e,d,c,b,a} for digits 0..9, dp off.
  localparam logic [7:0] FND_FONT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  // Clamp an out-of-range binary value to the largest displayable number.
  function automatic logic [BIN_W-1:0] sat_value(input logic [BIN_W-1:0] v);
    logic [BIN_W-1:0] r;
    if (v > MAX_VALUE_BIN) r = MAX_VALUE_BIN;
    else                   r = v;
    return r;
  endfunction

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    logic [3:0]       nib;
    r = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      nib = bcd[i*4 +: 4];
      if (nib >= 4'd5) r[i*4 +: 4] = nib + 4'd3;
      else             r[i*4 +: 4] = nib;
    end
    return r;
  endfunction

  // Map a BCD nibble to its segment pattern; non-decimal nibbles go dark.
  function automatic logic [7:0] font_encode(input logic [3:0] nib);
    logic [7:0] f;
    if (nib <= 4'd9) f = FND_FONT[nib];
    else             f = FND_BLANK;
    return f;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter (one bit per clock).
module bin2bcd_seq
  import fnd_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  conv_state_e              state_r;
  logic [BIN_W-1:0]         bin_r;
  logic [BCD_W-1:0]         scratch_r;
  logic [3:0]               cnt_r;
  logic                     busy_r;
  logic                     done_r;
  logic [BCD_W+BIN_W-1:0]   shift_s;

  // Corrected scratch concatenated with the remaining binary bits, before the shift.
  always_comb begin
    shift_s = {bcd_add3(scratch_r), bin_r};
  end

  // Conversion FSM: latch a saturated value, run 14 adjust/shift steps, flag completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      bin_r     <= '0;
      scratch_r <= '0;
      cnt_r     <= 4'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            bin_r     <= sat_value(bin);
            scratch_r <= '0;
            cnt_r     <= SHIFT_COUNT;
            busy_r    <= 1'b1;
            state_r   <= ST_SHIFT;
          end else begin
            busy_r    <= 1'b0;
          end
        end
        ST_SHIFT: begin
          {scratch_r, bin_r} <= {shift_s[BCD_W+BIN_W-2:0], 1'b0};
          cnt_r              <= cnt_r - 4'd1;
          if (cnt_r == 4'd1) begin
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            done_r  <= 1'b0;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign bcd  = scratch_r;

endmodule

// File: rtl/fnd_scan_controller.sv
// 4-digit common-anode 7-segment scan controller with sequential BCD conversion.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 100_000_000,
  parameter int SCAN_HZ       = 1000,
  parameter int BLANK_LEADING = 1
)(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [13:0] i_value,
  output logic [3:0]  o_fnd_com,
  output logic [7:0]  o_fnd_font,
  output logic [15:0] o_bcd,
  output logic        o_busy
);

  localparam int              DIV      = CLK_FREQ_HZ / SCAN_HZ;
  localparam int              DIV_W    = $clog2(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0]  div_r;
  logic              tick_s;
  logic [1:0]        digit_idx_r;
  logic [BIN_W-1:0]  last_value_r;
  logic              last_valid_r;
  logic              start_s;
  logic              conv_busy_s;
  logic              conv_done_s;
  logic [BCD_W-1:0]  conv_bcd_s;
  logic [BCD_W-1:0]  bcd_r;
  logic [3:0]        digit_nib_s;
  logic              blank_s;
  logic [3:0]        com_s;
  logic [7:0]        font_s;
  logic [3:0]        com_r;
  logic [7:0]        font_r;

  assign tick_s = (div_r == DIV_LAST);

  // Scan divider: count 0..DIV-1 and wrap.
  always_ff @(posedge i_clk) begin
    if (i_reset)     div_r <= '0;
    else if (tick_s) div_r <= '0;
    else             div_r <= div_r + DIV_W'(1);
  end

  // Digit index advances once per scan tick, wrapping 3 -> 0.
  always_ff @(posedge i_clk) begin
    if (i_reset)     digit_idx_r <= 2'd0;
    else if (tick_s) digit_idx_r <= digit_idx_r + 2'd1;
    else             digit_idx_r <= digit_idx_r;
  end

  // Start a conversion from idle whenever no value was seen yet or the input moved.
  always_comb begin
    start_s = 1'b0;
    if (!conv_busy_s && (!last_valid_r || (i_value != last_value_r))) start_s = 1'b1;
    else                                                              start_s = 1'b0;
  end

  // Remember the raw value that was handed to the converter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      last_value_r <= '0;
      last_valid_r <= 1'b0;
    end else if (start_s) begin
      last_value_r <= i_value;
      last_valid_r <= 1'b1;
    end else begin
      last_value_r <= last_value_r;
      last_valid_r <= last_valid_r;
    end
  end

  bin2bcd_seq u_bin2bcd (
    .clk   (i_clk),
    .reset (i_reset),
    .start (start_s),
    .bin   (i_value),
    .busy  (conv_busy_s),
    .done  (conv_done_s),
    .bcd   (conv_bcd_s)
  );

  // Displayed BCD is replaced in one step only when a conversion has completed.
  always_ff @(posedge i_clk) begin
    if (i_reset)          bcd_r <= '0;
    else if (conv_done_s) bcd_r <= conv_bcd_s;
    else                  bcd_r <= bcd_r;
  end

  // Select the current digit's nibble and decide whether it is a leading zero.
  always_comb begin
    digit_nib_s = 4'd0;
    blank_s     = 1'b0;
    case (digit_idx_r)
      2'd0: begin
        digit_nib_s = bcd_r[3:0];
        blank_s     = 1'b0;
      end
      2'd1: begin
        digit_nib_s = bcd_r[7:4];
        blank_s     = (bcd_r[15:4] == 12'd0);
      end
      2'd2: begin
        digit_nib_s = bcd_r[11:8];
        blank_s     = (bcd_r[15:8] == 8'd0);
      end
      2'd3: begin
        digit_nib_s = bcd_r[15:12];
        blank_s     = (bcd_r[15:12] == 4'd0);
      end
      default: begin
        digit_nib_s = 4'd0;
        blank_s     = 1'b0;
      end
    endcase
  end

  // Next common enable and segment pattern for the selected digit.
  always_comb begin
    com_s  = ~(4'b0001 << digit_idx_r);
    font_s = FND_BLANK;
    if ((BLANK_LEADING != 0) && blank_s) font_s = FND_BLANK;
    else                                 font_s = font_encode(digit_nib_s);
  end

  // Registered display drive.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      com_r  <= 4'b1111;
      font_r <= FND_BLANK;
    end else begin
      com_r  <= com_s;
      font_r <= font_s;
    end
  end

  assign o_fnd_com  = com_r;
  assign o_fnd_font = font_r;
  assign o_bcd      = bcd_r;
  assign o_busy     = conv_busy_s;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Scoreboard bench: stimulus queues expected decimal results, a negedge monitor checks the DUTs.
module tb_fnd_scan_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] val;

  logic [3:0]  com1, com0;
  logic [7:0]  font1, font0;
  logic [15:0] bcd1, bcd0;
  logic        busy1, busy0;

  int checks = 0;
  int errors = 0;
  int sb_q[$];
  int cur_raw = 0;

  localparam logic [7:0] SEG [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  always #5 clk = ~clk;

  fnd_scan_controller #(.CLK_FREQ_HZ(1000), .SCAN_HZ(250), .BLANK_LEADING(1)) dut_blank (
    .i_clk(clk), .i_reset(rst), .i_value(val),
    .o_fnd_com(com1), .o_fnd_font(font1), .o_bcd(bcd1), .o_busy(busy1)
  );

  fnd_scan_controller #(.CLK_FREQ_HZ(1000), .SCAN_HZ(250), .BLANK_LEADING(0)) dut_show (
    .i_clk(clk), .i_reset(rst), .i_value(val),
    .o_fnd_com(com0), .o_fnd_font(font0), .o_bcd(bcd0), .o_busy(busy0)
  );

  function automatic int sat(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic int to_bcd(input int v);
    return (((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) |
           (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  function automatic int exp_font(input int v, input int d, input bit blank);
    int p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    if (blank && d > 0 && v < p) return 8'hFF;
    return int'(SEG[(v / p) % 10]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_value(input int v, input int hold);
    val = 14'(v);
    if (v != cur_raw) begin
      sb_q.push_back(sat(v));
      cur_raw = v;
    end
    cycles(hold);
  endtask

  task automatic pulse_reset(input int n);
    rst = 1'b1;
    sb_q.delete();
    cycles(n);
    rst = 1'b0;
    sb_q.push_back(sat(cur_raw));
  endtask

  // Monitor state
  bit rst_prev  = 1'b1;
  bit busy_prev = 1'b0;
  int k         = 0;
  int busy_cnt  = 0;
  int model_val = 0;
  int font_val  = 0;

  initial begin : monitor
    int d;
    int exp_com;
    forever begin
      @(negedge clk);
      if (rst_prev) begin
        chk("reset_com", int'(com1), 4'hF);
        chk("reset_font", int'(font1), 8'hFF);
        chk("reset_bcd", int'(bcd1), 0);
        chk("reset_busy", int'(busy1), 0);
        chk("reset_com_nb", int'(com0), 4'hF);
        model_val = 0;
        font_val  = 0;
        busy_prev = 1'b0;
        busy_cnt  = 0;
        k         = 0;
      end else begin
        d       = (k / 4) % 4;
        exp_com = 15 ^ (1 << d);
        chk("scan_com", int'(com1), exp_com);
        chk("scan_com_nb", int'(com0), exp_com);
        chk("font_blank", int'(font1), exp_font(font_val, d, 1'b1));
        chk("font_show", int'(font0), exp_font(font_val, d, 1'b0));
        if (busy1) busy_cnt++;
        if (busy_prev && !busy1) begin
          chk("busy_len", busy_cnt, 15);
          busy_cnt = 0;
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_conversion bcd=%h expected=none", bcd1);
          end else begin
            model_val = sb_q.pop_front();
          end
        end
        chk("bcd", int'(bcd1), to_bcd(model_val));
        chk("bcd_nb", int'(bcd0), to_bcd(model_val));
        font_val  = model_val;
        busy_prev = busy1;
        k++;
      end
      rst_prev = rst;
    end
  end

  initial begin : stimulus
    int v;
    int v2;
    rst = 1'b1;
    val = 14'd0;
    cur_raw = 0;
    cycles(5);
    rst = 1'b0;
    sb_q.push_back(0);
    cycles(40);

    set_value(1234, 40);
    set_value(9999, 20);
    set_value(10000, 20);
    set_value(16383, 40);
    set_value(7, 3);
    set_value(2048, 40);
    set_value(40, 40);
    set_value(5678, 5);
    pulse_reset(2);
    cycles(40);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) v = $urandom_range(9990, 10010);
      else                           v = $urandom_range(0, 16383);
      if ($urandom_range(0, 5) == 0) v = cur_raw;
      if ($urandom_range(0, 3) == 0) begin
        set_value(v, 3);
        v2 = $urandom_range(0, 16383);
        set_value(v2, 40);
      end else begin
        set_value(v, 20);
      end
    end

    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d expected=0", sb_q.size());
    end
    cycles(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
